// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared writeback types and pointer helper for the port arbiter
package wb_port_arbiter_pkg;
  localparam int WB_ID_WIDTH = 3;
  localparam int WB_DATA_WIDTH = 32;
  typedef logic [WB_ID_WIDTH-1:0] id_t;
  typedef struct packed {
    logic valid;
    id_t id;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_packet_t;
  function automatic int unsigned wrap_inc(input int unsigned k, input int unsigned n);
    return (k + 1 == n) ? 0 : k + 1;
  endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: unit-side requests and registered writeback packet of one group
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int ID_WIDTH = WB_ID_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
);
  logic [NUM_UNITS-1:0] unit_done;
  logic [NUM_UNITS-1:0][ID_WIDTH-1:0] unit_id;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_data;
  logic [NUM_UNITS-1:0] unit_ack;
  logic port_ready;
  logic wb_valid;
  logic [ID_WIDTH-1:0] wb_id;
  logic [DATA_WIDTH-1:0] wb_data;
  logic starve_event;
  modport master (
    output unit_done, unit_id, unit_data, port_ready,
    input unit_ack, wb_valid, wb_id, wb_data, starve_event
  );
  modport slave (
    input unit_done, unit_id, unit_data, port_ready,
    output unit_ack, wb_valid, wb_id, wb_data, starve_event
  );
endinterface

// File: rtl/wb_port_arbiter_rr_select.sv
// rr_priority_select: first set request at or after ptr, wrapping, via double-width priority encode
module rr_priority_select #(
  parameter int N = 4,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  localparam int PW = $clog2(2 * N);
  logic [2*N-1:0] dbl;
  logic [PW-1:0] pos;
  // low half keeps only requests at or above ptr; upper half supplies the wrapped-around ones
  always_comb begin
    dbl = {req, req & ~((N'(1) << ptr) - N'(1))};
    pos = '0;
    for (int i = 2 * N - 1; i >= 0; i--) pos = dbl[i] ? PW'(i) : pos;
    idx = IW'(pos >= PW'(N) ? pos - PW'(N) : pos);
    gnt = req & (N'(1) << idx);
    any = |req;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: rotating-priority writeback port select with starvation guard and registered packet
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ID_WIDTH = WB_ID_WIDTH,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  wb_port_arbiter_if.slave bus
);
  localparam int IW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef struct packed {
    logic valid;
    logic [ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, rr_idx, f_idx, sel_idx;
  logic [NUM_UNITS-1:0] rr_gnt, f_gnt, starved, ack;
  logic rr_any, f_any, grant;
  logic [NUM_UNITS-1:0][CW-1:0] cnt_q, cnt_d;
  pkt_t pkt_q, pkt_d;
  logic starve_q, starve_d;
  rr_priority_select #(.N(NUM_UNITS), .IW(IW)) u_rr (
    .req(bus.unit_done), .ptr(rr_ptr_q), .gnt(rr_gnt), .idx(rr_idx), .any(rr_any)
  );
  // pointer tied to 0 makes this a plain lowest-index pick among starved units
  rr_priority_select #(.N(NUM_UNITS), .IW(IW)) u_starve (
    .req(starved), .ptr('0), .gnt(f_gnt), .idx(f_idx), .any(f_any)
  );
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++)
      starved[i] = bus.unit_done[i] && cnt_q[i] == CW'(STARVE_LIMIT);
    grant = bus.port_ready && !rst && rr_any;
    sel_idx = f_any ? f_idx : rr_idx;
    ack = grant ? (f_any ? f_gnt : rr_gnt) : '0;
    rr_ptr_d = grant ? IW'(wrap_inc(32'(sel_idx), NUM_UNITS)) : rr_ptr_q;
    for (int i = 0; i < NUM_UNITS; i++)
      cnt_d[i] = (ack[i] || !bus.unit_done[i]) ? '0 :
                 cnt_q[i] == CW'(STARVE_LIMIT) ? cnt_q[i] : cnt_q[i] + CW'(1);
    pkt_d = grant ? {1'b1, bus.unit_id[sel_idx], bus.unit_data[sel_idx]} :
                    {1'b0, pkt_q.id, pkt_q.data};
    starve_d = grant && f_any;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cnt_q <= '0;
      pkt_q <= '0;
      starve_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
      starve_q <= starve_d;
    end
  end
  assign bus.unit_ack = ack;
  assign bus.wb_valid = pkt_q.valid;
  assign bus.wb_id = pkt_q.id;
  assign bus.wb_data = pkt_q.data;
  assign bus.starve_event = starve_q;
endmodule
